// File: rtl/overture_io_port_if.sv
// Bus bundle between the OVERTURE I/O port and the CPU / host harness.
// OVERTURE_IO_ERRCNT_EN adds the saturating error counters to the bundle.
interface overture_io_port_if #(
  parameter int unsigned LW = 3
);
  logic          arch_input_enable;
  logic [7:0]    arch_input_value;
  logic          arch_output_enable;
  logic [7:0]    arch_output_value;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [LW-1:0] in_level;
  logic [LW-1:0] out_level;
  logic          underflow;
  logic          overflow;
  logic          clear_flags;
`ifdef OVERTURE_IO_ERRCNT_EN
  logic [7:0]    underflow_cnt;
  logic [7:0]    overflow_cnt;
`endif

  // Harness side: CPU model plus host stream endpoints
  modport master (
    output arch_input_enable, arch_output_enable, arch_output_value,
    output in_valid, in_data, out_ready, clear_flags,
    input  arch_input_value, in_ready, out_valid, out_data,
    input  in_level, out_level, underflow, overflow
`ifdef OVERTURE_IO_ERRCNT_EN
    , input underflow_cnt, overflow_cnt
`endif
  );

  // I/O port side
  modport slave (
    input  arch_input_enable, arch_output_enable, arch_output_value,
    input  in_valid, in_data, out_ready, clear_flags,
    output arch_input_value, in_ready, out_valid, out_data,
    output in_level, out_level, underflow, overflow
`ifdef OVERTURE_IO_ERRCNT_EN
    , output underflow_cnt, overflow_cnt
`endif
  );
endinterface

// File: rtl/overture_io_port.sv
// Host-side I/O endpoint for the OVERTURE CPU: input and output byte FIFOs, never stalling the CPU.
// OVERTURE_IO_ERRCNT_EN adds saturating underflow/overflow event counters.
module overture_io_port #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  overture_io_port_if.slave  io
);
  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [7:0]    in_mem_q  [DEPTH];
  logic [PW-1:0] in_wp_q, in_rp_q;
  logic [LW-1:0] in_lvl_q, in_lvl_d;
  logic [7:0]    out_mem_q [DEPTH];
  logic [PW-1:0] out_wp_q, out_rp_q;
  logic [LW-1:0] out_lvl_q, out_lvl_d;
  logic          uf_q, of_q;

  logic in_empty, in_push, in_pop, uf_evt;
  logic out_empty, out_full, out_push, out_pop, of_evt;

  assign in_empty  = (in_lvl_q == '0);
  assign in_push   = io.in_valid && io.in_ready;
  assign in_pop    = io.arch_input_enable && !in_empty;
  assign uf_evt    = io.arch_input_enable && in_empty;

  assign out_empty = (out_lvl_q == '0);
  assign out_full  = (out_lvl_q == FULL_LVL);
  assign out_pop   = io.out_valid && io.out_ready;
  // A full FIFO still takes the CPU byte when the host frees a slot on the same edge
  assign out_push  = io.arch_output_enable && (!out_full || out_pop);
  assign of_evt    = io.arch_output_enable && out_full && !out_pop;

  assign io.arch_input_value = (io.arch_input_enable && !in_empty) ? in_mem_q[in_rp_q] : 8'h00;
  assign io.in_ready         = (in_lvl_q != FULL_LVL);
  assign io.out_valid        = !out_empty;
  assign io.out_data         = out_empty ? 8'h00 : out_mem_q[out_rp_q];
  assign io.in_level         = in_lvl_q;
  assign io.out_level        = out_lvl_q;
  assign io.underflow        = uf_q;
  assign io.overflow         = of_q;

  always_comb begin
    in_lvl_d  = in_lvl_q;
    out_lvl_d = out_lvl_q;
    case ({in_push, in_pop})
      2'b10:   in_lvl_d = in_lvl_q + LW'(1);
      2'b01:   in_lvl_d = in_lvl_q - LW'(1);
      default: in_lvl_d = in_lvl_q;
    endcase
    case ({out_push, out_pop})
      2'b10:   out_lvl_d = out_lvl_q + LW'(1);
      2'b01:   out_lvl_d = out_lvl_q - LW'(1);
      default: out_lvl_d = out_lvl_q;
    endcase
  end

  // Storage carries no reset: empty FIFOs never expose their contents
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wp_q]   <= io.in_data;
    if (out_push) out_mem_q[out_wp_q] <= io.arch_output_value;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      in_lvl_q  <= '0;
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_lvl_q <= '0;
      uf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      if (in_push)  in_wp_q  <= in_wp_q + PW'(1);
      if (in_pop)   in_rp_q  <= in_rp_q + PW'(1);
      if (out_push) out_wp_q <= out_wp_q + PW'(1);
      if (out_pop)  out_rp_q <= out_rp_q + PW'(1);
      in_lvl_q  <= in_lvl_d;
      out_lvl_q <= out_lvl_d;
      if (io.clear_flags) begin
        uf_q <= 1'b0;
        of_q <= 1'b0;
      end else begin
        if (uf_evt) uf_q <= 1'b1;
        if (of_evt) of_q <= 1'b1;
      end
    end
  end

`ifdef OVERTURE_IO_ERRCNT_EN
  logic [7:0] uf_cnt_q, of_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uf_cnt_q <= 8'h00;
      of_cnt_q <= 8'h00;
    end else if (io.clear_flags) begin
      uf_cnt_q <= 8'h00;
      of_cnt_q <= 8'h00;
    end else begin
      if (uf_evt && (uf_cnt_q != 8'hFF)) uf_cnt_q <= uf_cnt_q + 8'd1;
      if (of_evt && (of_cnt_q != 8'hFF)) of_cnt_q <= of_cnt_q + 8'd1;
    end
  end

  assign io.underflow_cnt = uf_cnt_q;
  assign io.overflow_cnt  = of_cnt_q;
`endif
endmodule

// File: tb/tb_overture_io_port.sv
// Self-checking bench for overture_io_port: directed vector table, corner sequences, random run vs queue model.
module tb_overture_io_port;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  overture_io_port_if #(.LW(LW)) io();

  overture_io_port #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  typedef struct {
    bit iv; byte unsigned id; bit ie; bit oe; byte unsigned ov; bit rdy; bit clr;
    byte unsigned e_aiv; int e_il; int e_ol; bit e_ovld; byte unsigned e_od; bit e_uf; bit e_of;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned inq[$];
  byte unsigned outq[$];
  bit m_uf, m_of;
  int m_ucnt, m_ocnt;

  function automatic vec_t mk(bit iv, byte unsigned id, bit ie, bit oe, byte unsigned ov, bit rdy,
                              bit clr, byte unsigned e_aiv, int e_il, int e_ol, bit e_ovld,
                              byte unsigned e_od, bit e_uf, bit e_of);
    vec_t v;
    v.iv = iv; v.id = id; v.ie = ie; v.oe = oe; v.ov = ov; v.rdy = rdy; v.clr = clr;
    v.e_aiv = e_aiv; v.e_il = e_il; v.e_ol = e_ol; v.e_ovld = e_ovld; v.e_od = e_od;
    v.e_uf = e_uf; v.e_of = e_of;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    io.in_valid           = v.iv;
    io.in_data            = v.id;
    io.arch_input_enable  = v.ie;
    io.arch_output_enable = v.oe;
    io.arch_output_value  = v.ov;
    io.out_ready          = v.rdy;
    io.clear_flags        = v.clr;
  endtask

  task automatic model_reset();
    inq.delete();
    outq.delete();
    m_uf = 1'b0; m_of = 1'b0; m_ucnt = 0; m_ocnt = 0;
  endtask

  // Compare every observable output against the queue model (state before the coming edge)
  task automatic check_model(input vec_t v);
    int exp_aiv;
    exp_aiv = (v.ie && inq.size() != 0) ? int'(inq[0]) : 0;
    check("m.arch_input_value", 32'(io.arch_input_value), 32'(exp_aiv));
    check("m.in_ready", 32'(io.in_ready), 32'(inq.size() != DEPTH));
    check("m.in_level", 32'(io.in_level), 32'(inq.size()));
    check("m.out_valid", 32'(io.out_valid), 32'(outq.size() != 0));
    check("m.out_data", 32'(io.out_data), (outq.size() != 0) ? 32'(outq[0]) : 32'h0);
    check("m.out_level", 32'(io.out_level), 32'(outq.size()));
    check("m.underflow", 32'(io.underflow), 32'(m_uf));
    check("m.overflow", 32'(io.overflow), 32'(m_of));
`ifdef OVERTURE_IO_ERRCNT_EN
    check("m.underflow_cnt", 32'(io.underflow_cnt), 32'(m_ucnt));
    check("m.overflow_cnt", 32'(io.overflow_cnt), 32'(m_ocnt));
`endif
  endtask

  task automatic model_edge(input vec_t v);
    bit rd_empty, host_ok, opop, ofull;
    rd_empty = (inq.size() == 0);
    host_ok  = (inq.size() != DEPTH);
    if (v.ie && rd_empty) begin
      m_uf = 1'b1;
      if (m_ucnt < 255) m_ucnt++;
    end
    if (v.iv && host_ok) inq.push_back(v.id);
    if (v.ie && !rd_empty) void'(inq.pop_front());
    opop  = (outq.size() != 0) && v.rdy;
    ofull = (outq.size() == DEPTH);
    if (opop) void'(outq.pop_front());
    if (v.oe) begin
      if (!ofull || opop) outq.push_back(v.ov);
      else begin
        m_of = 1'b1;
        if (m_ocnt < 255) m_ocnt++;
      end
    end
    if (v.clr) begin
      m_uf = 1'b0; m_of = 1'b0; m_ucnt = 0; m_ocnt = 0;
    end
  endtask

  task automatic step(input vec_t v, input bit tbl);
    @(negedge clk);
    drive(v);
    #1;
    if (tbl) begin
      check("t.arch_input_value", 32'(io.arch_input_value), 32'(v.e_aiv));
      check("t.in_level", 32'(io.in_level), 32'(v.e_il));
      check("t.out_level", 32'(io.out_level), 32'(v.e_ol));
      check("t.out_valid", 32'(io.out_valid), 32'(v.e_ovld));
      check("t.out_data", 32'(io.out_data), 32'(v.e_od));
      check("t.underflow", 32'(io.underflow), 32'(v.e_uf));
      check("t.overflow", 32'(io.overflow), 32'(v.e_of));
    end
    check_model(v);
    model_edge(v);
    @(posedge clk);
    #1;
  endtask

  vec_t vq[$];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    #12;
    check("rst.in_ready", 32'(io.in_ready), 32'h1);
    check("rst.out_valid", 32'(io.out_valid), 32'h0);
    check("rst.out_data", 32'(io.out_data), 32'h0);
    check("rst.arch_input_value", 32'(io.arch_input_value), 32'h0);
    check("rst.in_level", 32'(io.in_level), 32'h0);
    check("rst.underflow", 32'(io.underflow), 32'h0);
    @(negedge clk);
    drive(idle);
    rst = 1'b1;

    // iv id ie oe ov rdy clr | aiv il ol ovld od uf of
    vq.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, 8'h22, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, 8'h33, 0, 0, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h11, 3, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h22, 2, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h33, 1, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hA0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hA1, 0, 0, 8'h00, 0, 1, 1, 8'hA0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hA2, 0, 0, 8'h00, 0, 2, 1, 8'hA0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hA3, 0, 0, 8'h00, 0, 3, 1, 8'hA0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hA4, 0, 0, 8'h00, 0, 4, 1, 8'hA0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4, 1, 8'hA0, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4, 1, 8'hA0, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 3, 1, 8'hA1, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2, 1, 8'hA2, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 1, 8'hA3, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hB1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hB2, 0, 0, 8'h00, 0, 1, 1, 8'hB1, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hB3, 0, 0, 8'h00, 0, 2, 1, 8'hB1, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hB4, 0, 0, 8'h00, 0, 3, 1, 8'hB1, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 8'hB5, 1, 0, 8'h00, 0, 4, 1, 8'hB1, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4, 1, 8'hB2, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4, 1, 8'hB2, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 3, 1, 8'hB3, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2, 1, 8'hB4, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 1, 8'hB5, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    foreach (vq[i]) step(vq[i], 1'b1);

    // Host push into empty input FIFO on the same edge as a CPU read: no bypass
    step(mk(1, 8'h5A, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0), 1'b1);
    check("same_edge.underflow", 32'(io.underflow), 32'h1);
    check("same_edge.in_level", 32'(io.in_level), 32'h1);
    step(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h5A, 1, 0, 0, 8'h00, 1, 0), 1'b1);
`ifdef OVERTURE_IO_ERRCNT_EN
    check("same_edge.underflow_cnt", 32'(io.underflow_cnt), 32'h1);
`endif
    step(mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0), 1'b1);
    check("clear.underflow", 32'(io.underflow), 32'h0);
`ifdef OVERTURE_IO_ERRCNT_EN
    check("clear.underflow_cnt", 32'(io.underflow_cnt), 32'h0);
`endif

    // Fill both FIFOs, overflow once, then reset mid-stream with CPU access in the reset cycle
    for (int i = 0; i < 5; i++)
      step(mk(1, 8'(8'hC0 + i), 0, 1, 8'(8'hD0 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check("full.in_ready", 32'(io.in_ready), 32'h0);
    check("full.overflow", 32'(io.overflow), 32'h1);
    @(negedge clk);
    drive(mk(1, 8'hEE, 1, 1, 8'hEF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst.in_level", 32'(io.in_level), 32'h0);
    check("midrst.out_valid", 32'(io.out_valid), 32'h0);
    check("midrst.out_level", 32'(io.out_level), 32'h0);
    check("midrst.overflow", 32'(io.overflow), 32'h0);
    check("midrst.underflow", 32'(io.underflow), 32'h0);
    check("midrst.in_ready", 32'(io.in_ready), 32'h1);
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    step(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0), 1'b1);
    check("postrst.in_ready", 32'(io.in_ready), 32'h1);

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      vec_t r;
      r = idle;
      r.iv  = ($urandom_range(0, 99) < 55);
      r.id  = 8'($urandom);
      r.ie  = ($urandom_range(0, 99) < 50);
      r.oe  = ($urandom_range(0, 99) < 55);
      r.ov  = 8'($urandom);
      r.rdy = ($urandom_range(0, 99) < 45);
      r.clr = ($urandom_range(0, 199) == 0);
      step(r, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
